// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard signal bundle: issue, ready and retire events, source reads, stall/busy.
interface hazard_scoreboard_if #(
    parameter int TAG_W = 3
);
    logic             issue_valid;
    logic             issue_ready;
    logic [4:0]       issue_dst;
    logic             issue_late;
    logic [TAG_W-1:0] issue_tag;
    logic             ready_valid;
    logic [4:0]       ready_dst;
    logic [TAG_W-1:0] ready_tag;
    logic             retire_valid;
    logic [4:0]       retire_dst;
    logic [TAG_W-1:0] retire_tag;
    logic             src1_valid;
    logic [4:0]       src1;
    logic             src2_valid;
    logic [4:0]       src2;
    logic             stall;
    logic             busy;

    // An issue fires when issue_valid & issue_ready are both high in the same cycle.
    // Ready and retire events carry no back-pressure; they are taken whenever their valid is high.
    modport master (
        output issue_valid, issue_dst, issue_late,
        output ready_valid, ready_dst, ready_tag,
        output retire_valid, retire_dst, retire_tag,
        output src1_valid, src1, src2_valid, src2,
        input  issue_ready, issue_tag, stall, busy
    );

    modport slave (
        input  issue_valid, issue_dst, issue_late,
        input  ready_valid, ready_dst, ready_tag,
        input  retire_valid, retire_dst, retire_tag,
        input  src1_valid, src1, src2_valid, src2,
        output issue_ready, issue_tag, stall, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers from issue to retire and stalls decode on unforwardable sources.
// HAZARD_NOFWD_EN: when defined, any pending writer stalls a reader (no forwarding).
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TAG_W = 3
) (
    input logic           clk,
    input logic           reset,
    hazard_scoreboard_if.slave sb
);
    localparam int RW = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic [TAG_W-1:0] ytag_q [NREG];
    logic [TAG_W-1:0] ytag_d [NREG];
    logic [NREG-1:0]  late_q;
    logic [NREG-1:0]  late_d;
    logic [TAG_W-1:0] ntag_q;
    logic [TAG_W-1:0] ntag_d;
    logic             fire;
    logic             haz1;
    logic             haz2;
    logic             lt1;
    logic             lt2;
    logic             busy_w;

    assign sb.issue_ready = (sb.issue_dst == '0) || (cnt_q[sb.issue_dst] != CNT_MAX);
    assign fire           = sb.issue_valid & sb.issue_ready;
    assign sb.issue_tag   = ntag_q;

    always_comb begin
        logic iss;
        logic rdy;
        logic ret;
        iss    = 1'b0;
        rdy    = 1'b0;
        ret    = 1'b0;
        ntag_d = fire ? ntag_q + TAG_W'(1) : ntag_q;
        cnt_d  = cnt_q;
        ytag_d = ytag_q;
        late_d = late_q;
        cnt_d[0]  = '0;
        ytag_d[0] = '0;
        late_d[0] = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            iss = fire && (sb.issue_dst == RW'(r));
            rdy = sb.ready_valid && (sb.ready_dst == RW'(r)) && (sb.ready_tag == ytag_q[r]);
            ret = sb.retire_valid && (sb.retire_dst == RW'(r));
            // Issue and retire together cancel; a retire at zero is a protocol error and is absorbed.
            if (iss && !ret)
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            else if (!iss && ret && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            if (iss) begin
                late_d[r] = sb.issue_late;
                ytag_d[r] = ntag_q;
            end else if (rdy || (ret && sb.retire_tag == ytag_q[r])) begin
                late_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r]  <= '0;
                ytag_q[r] <= '0;
            end
            late_q <= '0;
            ntag_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ytag_q <= ytag_d;
            late_q <= late_d;
            ntag_q <= ntag_d;
        end
    end

`ifdef HAZARD_NOFWD_EN
    assign lt1 = 1'b1;
    assign lt2 = 1'b1;
`else
    assign lt1 = late_q[sb.src1];
    assign lt2 = late_q[sb.src2];
`endif

    assign haz1 = sb.src1_valid && (sb.src1 != '0) && (cnt_q[sb.src1] != '0) && lt1;
    assign haz2 = sb.src2_valid && (sb.src2 != '0) && (cnt_q[sb.src2] != '0) && lt2;
    assign sb.stall = haz1 | haz2 | (sb.issue_valid & ~sb.issue_ready);

    always_comb begin
        busy_w = 1'b0;
        for (int r = 1; r < NREG; r++)
            busy_w = busy_w | (cnt_q[r] != '0);
    end
    assign sb.busy = busy_w;
endmodule
